npc_seq_ctrl: RTL and testbench

NPC_SEQ_CTRL -- requirements
Module: npc_seq_ctrl

---
 rtl/npc_pkg.sv | 27 ++
 rtl/npc_wait_timer.sv | 29 ++
 rtl/npc_seq_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_npc_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the NPC sequencing controller: FSM state encodings,
// trap cause codes and the memory-fault cause helper.
package npc_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6,
        ST_HALT   = 3'd7
    } npc_state_e;

    localparam logic [3:0] CAUSE_NONE        = 4'd0;
    localparam logic [3:0] CAUSE_FETCH_FAULT = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;
    localparam logic [3:0] CAUSE_ECALL       = 4'd11;

    function automatic logic [3:0] mem_fault_cause(input logic is_store);
        return is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
    endfunction

endpackage

// File: rtl/npc_wait_timer.sv
// Memory wait timer: counts consecutive cycles spent waiting on a handshake
// and flags expiry on the LIMIT-th waiting cycle.
module npc_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    output logic expired
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count_r;

    assign expired = active && (count_r == CW'(LIMIT - 1));

    // Wait-cycle counter, cleared whenever no request is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (!active || expired) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

endmodule

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle instruction sequencer for the NPC core (fetch/decode/exec/mem/wb).
// Optional memory wait timeout is enabled with the NPC_SEQ_TIMEOUT_EN macro.
module npc_seq_ctrl
    import npc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        dec_reg_wen,
    input  logic        dec_mem_ren,
    input  logic        dec_mem_wen,
    input  logic        dec_csr_wen,
    input  logic        dec_illegal,
    input  logic        dec_ecall,
    input  logic        dec_ebreak,
    output logic        ir_wen,
    output logic        pc_wen,
    output logic        rf_wen,
    output logic        csr_wen,
    output logic        exr_wen,
    output logic        trap_wen,
    output logic        pc_sel,
    output logic [3:0]  trap_cause,
    output logic        halt,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    npc_state_e  state_r;
    npc_state_e  next_state_s;
    logic [3:0]  next_cause_s;
    logic        wait_expired_s;
    logic        retire_s;
    logic        unused_s;

    logic        dec_reg_wen_r;
    logic        dec_mem_ren_r;
    logic        dec_mem_wen_r;
    logic        dec_csr_wen_r;
    logic        dec_illegal_r;
    logic        dec_ecall_r;
    logic        dec_ebreak_r;

    logic        imem_req_r;
    logic        dmem_req_r;
    logic        dmem_we_r;
    logic        pc_wen_r;
    logic        rf_wen_r;
    logic        csr_wen_r;
    logic        exr_wen_r;
    logic        trap_wen_r;
    logic        pc_sel_r;
    logic [3:0]  trap_cause_r;
    logic        halt_r;
    logic [31:0] instret_r;

`ifdef NPC_SEQ_TIMEOUT_EN
    npc_wait_timer #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst),
        .active  ((state_r == ST_FETCH) || (state_r == ST_MEM)),
        .expired (wait_expired_s)
    );
    assign unused_s = ^{dec_illegal_r, dec_ecall_r, dec_ebreak_r};
`else
    assign wait_expired_s = 1'b0;
    assign unused_s = ^{dec_illegal_r, dec_ecall_r, dec_ebreak_r, (TIMEOUT_CYCLES == 32'd0)};
`endif

    // Next-state and trap-cause selection.
    always_comb begin
        next_state_s = state_r;
        next_cause_s = CAUSE_NONE;
        case (state_r)
            ST_RESET:  next_state_s = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready) begin
                    next_state_s = ST_DECODE;
                end else if (wait_expired_s) begin
                    next_state_s = ST_TRAP;
                    next_cause_s = CAUSE_FETCH_FAULT;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    next_state_s = ST_TRAP;
                    next_cause_s = CAUSE_ILLEGAL;
                end else if (dec_ebreak) begin
                    next_state_s = ST_HALT;
                end else if (dec_ecall) begin
                    next_state_s = ST_TRAP;
                    next_cause_s = CAUSE_ECALL;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec_mem_ren_r || dec_mem_wen_r) begin
                    next_state_s = ST_MEM;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    next_state_s = ST_WB;
                end else if (wait_expired_s) begin
                    next_state_s = ST_TRAP;
                    next_cause_s = mem_fault_cause(dec_mem_wen_r);
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WB:     next_state_s = ST_FETCH;
            ST_TRAP:   next_state_s = ST_FETCH;
            ST_HALT:   next_state_s = ST_HALT;
            default:   next_state_s = ST_RESET;
        endcase
    end

    // An instruction retires on entry to WB, or on entry to HALT (ebreak).
    assign retire_s = (next_state_s == ST_WB) ||
                      ((next_state_s == ST_HALT) && (state_r != ST_HALT));

    // State register, latched decode flags and outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_RESET;
            dec_reg_wen_r <= 1'b0;
            dec_mem_ren_r <= 1'b0;
            dec_mem_wen_r <= 1'b0;
            dec_csr_wen_r <= 1'b0;
            dec_illegal_r <= 1'b0;
            dec_ecall_r   <= 1'b0;
            dec_ebreak_r  <= 1'b0;
            imem_req_r    <= 1'b0;
            dmem_req_r    <= 1'b0;
            dmem_we_r     <= 1'b0;
            pc_wen_r      <= 1'b0;
            rf_wen_r      <= 1'b0;
            csr_wen_r     <= 1'b0;
            exr_wen_r     <= 1'b0;
            trap_wen_r    <= 1'b0;
            pc_sel_r      <= 1'b0;
            trap_cause_r  <= CAUSE_NONE;
            halt_r        <= 1'b0;
            instret_r     <= 32'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_DECODE) begin
                dec_reg_wen_r <= dec_reg_wen;
                dec_mem_ren_r <= dec_mem_ren;
                dec_mem_wen_r <= dec_mem_wen;
                dec_csr_wen_r <= dec_csr_wen;
                dec_illegal_r <= dec_illegal;
                dec_ecall_r   <= dec_ecall;
                dec_ebreak_r  <= dec_ebreak;
            end
            imem_req_r   <= (next_state_s == ST_FETCH);
            dmem_req_r   <= (next_state_s == ST_MEM);
            dmem_we_r    <= (next_state_s == ST_MEM) && dec_mem_wen_r;
            exr_wen_r    <= (next_state_s == ST_EXEC);
            pc_wen_r     <= (next_state_s == ST_WB) || (next_state_s == ST_TRAP);
            pc_sel_r     <= (next_state_s == ST_TRAP);
            rf_wen_r     <= (next_state_s == ST_WB) && dec_reg_wen_r;
            csr_wen_r    <= (next_state_s == ST_WB) && dec_csr_wen_r;
            trap_wen_r   <= (next_state_s == ST_TRAP);
            trap_cause_r <= next_cause_s;
            halt_r       <= (next_state_s == ST_HALT);
            if (retire_s) begin
                instret_r <= instret_r + 32'd1;
            end
        end
    end

    // The IR must capture fetch data on the same edge that samples imem_ready,
    // so this strobe is the one output decoded directly from the handshake.
    assign ir_wen     = (state_r == ST_FETCH) && imem_ready;

    assign imem_req   = imem_req_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign pc_wen     = pc_wen_r;
    assign rf_wen     = rf_wen_r;
    assign csr_wen    = csr_wen_r;
    assign exr_wen    = exr_wen_r;
    assign trap_wen   = trap_wen_r;
    assign pc_sel     = pc_sel_r;
    assign trap_cause = trap_cause_r;
    assign halt       = halt_r;
    assign instret    = instret_r;
    assign state      = state_r;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Self-checking bench for npc_seq_ctrl: instruction-level plans expand into
// per-cycle {inputs, expected outputs} records that are applied in a loop.
`timescale 1ns/1ps
module tb_npc_seq_ctrl;
    import npc_pkg::*;

    localparam int TO = 4;
`ifdef NPC_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk, rst;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
    logic        dec_reg_wen, dec_mem_ren, dec_mem_wen, dec_csr_wen;
    logic        dec_illegal, dec_ecall, dec_ebreak;
    logic        ir_wen, pc_wen, rf_wen, csr_wen, exr_wen, trap_wen, pc_sel, halt;
    logic [3:0]  trap_cause;
    logic [31:0] instret;
    logic [2:0]  state;

    npc_seq_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .dec_reg_wen(dec_reg_wen), .dec_mem_ren(dec_mem_ren), .dec_mem_wen(dec_mem_wen),
        .dec_csr_wen(dec_csr_wen), .dec_illegal(dec_illegal), .dec_ecall(dec_ecall),
        .dec_ebreak(dec_ebreak),
        .ir_wen(ir_wen), .pc_wen(pc_wen), .rf_wen(rf_wen), .csr_wen(csr_wen),
        .exr_wen(exr_wen), .trap_wen(trap_wen), .pc_sel(pc_sel),
        .trap_cause(trap_cause), .halt(halt), .instret(instret), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        imem_req, dmem_req, dmem_we, ir_wen, pc_wen, pc_sel;
        logic        rf_wen, csr_wen, exr_wen, trap_wen, halt;
        logic [3:0]  trap_cause;
        logic [2:0]  state;
        logic [31:0] instret;
    } outs_t;

    // dec bit order: {reg_wen, mem_ren, mem_wen, csr_wen, illegal, ecall, ebreak}
    typedef struct {
        logic       imem_ready;
        logic       dmem_ready;
        logic [6:0] dec;
        outs_t      exp;
        int         ino;
    } vec_t;

    vec_t        vq[$];
    int          n_vec, n_bad, cur_ino;
    logic [31:0] m_instret;

    function automatic logic [6:0] mk_dec(input bit r, input bit lr, input bit sw,
                                          input bit c, input bit il, input bit ec, input bit eb);
        return {r, lr, sw, c, il, ec, eb};
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] noise();
        return 7'($urandom);
    endfunction

    function automatic outs_t base(input npc_state_e st);
        outs_t o;
        o = '0;
        o.state = st;
        o.instret = m_instret;
        return o;
    endfunction

    task automatic add(input logic ir, input logic dr, input logic [6:0] dec, input outs_t e);
        vec_t v;
        v.imem_ready = ir;
        v.dmem_ready = dr;
        v.dec = dec;
        v.exp = e;
        v.ino = cur_ino;
        vq.push_back(v);
    endtask

    task automatic push_trap(input logic [3:0] cause);
        outs_t o;
        o = base(ST_TRAP);
        o.trap_wen = 1'b1;
        o.pc_wen = 1'b1;
        o.pc_sel = 1'b1;
        o.trap_cause = cause;
        add(rnd1(), rnd1(), noise(), o);
    endtask

    // One instruction from the outside: fetch (with waits), decode, then the
    // outcome dictated by the decode flags. stall_mem stops inside MEM.
    task automatic plan_instr(input logic [6:0] dec, input int fwait, input int dwait,
                              input bit stall_mem);
        outs_t o;
        bit r, lr, sw, c, il, ec, eb;
        {r, lr, sw, c, il, ec, eb} = dec;
        cur_ino++;
        o = base(ST_FETCH);
        o.imem_req = 1'b1;
        if (TO_EN && fwait >= TO) begin
            repeat (TO) add(1'b0, rnd1(), noise(), o);
            push_trap(4'd1);
            return;
        end
        repeat (fwait) add(1'b0, rnd1(), noise(), o);
        o.ir_wen = 1'b1;
        add(1'b1, rnd1(), noise(), o);
        add(rnd1(), rnd1(), dec, base(ST_DECODE));
        if (il) begin
            push_trap(4'd2);
            return;
        end
        if (eb) begin
            m_instret = m_instret + 32'd1;
            o = base(ST_HALT);
            o.halt = 1'b1;
            repeat (21) add(rnd1(), rnd1(), noise(), o);
            return;
        end
        if (ec) begin
            push_trap(4'd11);
            return;
        end
        o = base(ST_EXEC);
        o.exr_wen = 1'b1;
        add(rnd1(), rnd1(), noise(), o);
        if (lr || sw) begin
            o = base(ST_MEM);
            o.dmem_req = 1'b1;
            o.dmem_we = sw;
            if (stall_mem) begin
                repeat (dwait) add(rnd1(), 1'b0, noise(), o);
                return;
            end
            if (TO_EN && dwait >= TO) begin
                repeat (TO) add(rnd1(), 1'b0, noise(), o);
                push_trap(sw ? 4'd7 : 4'd5);
                return;
            end
            repeat (dwait) add(rnd1(), 1'b0, noise(), o);
            add(rnd1(), 1'b1, noise(), o);
        end
        m_instret = m_instret + 32'd1;
        o = base(ST_WB);
        o.pc_wen = 1'b1;
        o.rf_wen = r;
        o.csr_wen = c;
        add(rnd1(), rnd1(), noise(), o);
    endtask

    function automatic outs_t sample();
        outs_t a;
        a.imem_req = imem_req;   a.dmem_req = dmem_req;     a.dmem_we = dmem_we;
        a.ir_wen = ir_wen;       a.pc_wen = pc_wen;         a.pc_sel = pc_sel;
        a.rf_wen = rf_wen;       a.csr_wen = csr_wen;       a.exr_wen = exr_wen;
        a.trap_wen = trap_wen;   a.halt = halt;             a.trap_cause = trap_cause;
        a.state = state;         a.instret = instret;
        return a;
    endfunction

    task automatic check(input outs_t e, input string name);
        outs_t a;
        a = sample();
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h (state %0d/%0d instret %0d/%0d)",
                     name, a, e, a.state, e.state, a.instret, e.instret);
        end
    endtask

    task automatic apply_all();
        vec_t v;
        while (vq.size() > 0) begin
            v = vq.pop_front();
            @(negedge clk);
            imem_ready = v.imem_ready;
            dmem_ready = v.dmem_ready;
            {dec_reg_wen, dec_mem_ren, dec_mem_wen, dec_csr_wen,
             dec_illegal, dec_ecall, dec_ebreak} = v.dec;
            #1;
            check(v.exp, $sformatf("instr%0d", v.ino));
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        add(1'b0, 1'b0, 7'd0, base(ST_RESET));
    endtask

    initial begin
        n_vec = 0; n_bad = 0; cur_ino = 0; m_instret = 32'd0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        {dec_reg_wen, dec_mem_ren, dec_mem_wen, dec_csr_wen,
         dec_illegal, dec_ecall, dec_ebreak} = 7'd0;
        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        #1 check(base(ST_RESET), "reset_hold");
        release_reset();

        // Directed instructions
        plan_instr(mk_dec(1, 0, 0, 0, 0, 0, 0), 0, 0, 1'b0);  // addi
        plan_instr(mk_dec(1, 1, 0, 0, 0, 0, 0), 0, 3, 1'b0);  // lw, ready after 3 waits
        plan_instr(mk_dec(1, 0, 0, 0, 1, 0, 1), 0, 0, 1'b0);  // illegal beats ebreak
        plan_instr(mk_dec(0, 0, 0, 0, 0, 1, 0), 1, 0, 1'b0);  // ecall
        plan_instr(mk_dec(1, 0, 0, 1, 0, 0, 0), 2, 0, 1'b0);  // csr write
        plan_instr(mk_dec(0, 0, 1, 0, 0, 0, 0), 1, 2, 1'b0);  // sw
        plan_instr(mk_dec(1, 0, 0, 0, 0, 0, 0), 6, 0, 1'b0);  // long fetch stall
        plan_instr(mk_dec(0, 0, 1, 0, 0, 0, 0), 0, 5, 1'b0);  // long store stall
        apply_all();

        // Random instruction stream
        for (int i = 0; i < 150; i++) begin
            plan_instr(mk_dec(rnd1(), rnd1(), ($urandom_range(0, 3) == 0), rnd1(),
                              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b0),
                       $urandom_range(0, 5), $urandom_range(0, 5), 1'b0);
        end
        apply_all();

        // Reset asserted while a load is waiting in MEM
        plan_instr(mk_dec(1, 1, 0, 0, 0, 0, 0), 0, 2, 1'b1);
        apply_all();
        @(posedge clk);
        #2 rst = 1'b0;
        m_instret = 32'd0;
        #1 check(base(ST_RESET), "async_reset_mid_mem");
        @(negedge clk);
        #1 check(base(ST_RESET), "reset_held");
        release_reset();

        // ebreak (with ecall also set) halts for good; instret counts it once
        plan_instr(mk_dec(1, 0, 0, 0, 0, 0, 0), 0, 0, 1'b0);
        plan_instr(mk_dec(0, 0, 0, 0, 0, 1, 1), 1, 0, 1'b0);
        apply_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
